// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: register offsets, sequencer states and read default shared by apb_pwm_seq
package pwm_seq_pkg;
    localparam logic [5:0]  OFF_CTRL      = 6'h00;
    localparam logic [5:0]  OFF_STATUS    = 6'h04;
    localparam logic [5:0]  OFF_PRE       = 6'h08;
    localparam logic [5:0]  OFF_TMRCMP1   = 6'h0C;
    localparam logic [5:0]  OFF_REPS      = 6'h10;
    localparam logic [5:0]  OFF_LEN       = 6'h14;
    localparam logic [5:0]  OFF_DUTY_BASE = 6'h20;
    localparam logic [31:0] RD_DEFAULT    = 32'hDEADBEEF;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
endpackage

// File: rtl/pwm_seq_fsm.sv
// pwm_seq_fsm: step/repeat sequencer that loads the TMRCMP2 shadow from the duty table
module pwm_seq_fsm
    import pwm_seq_pkg::*;
#(
    parameter int IW = 2
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          loop_i,
    input  logic          period_end_i,
    input  logic [15:0]   reps_i,
    input  logic [IW-1:0] len_i,
    input  logic [31:0]   duty_i,
    output logic [IW-1:0] duty_idx_o,
    output state_e        state_o,
    output logic [IW-1:0] idx_o,
    output logic [31:0]   tmrcmp2_o,
    output logic          tmren_o,
    output logic          done_set_o
);
    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   rep_q, rep_d;
    logic [31:0]   cmp2_q;
    logic          step_end, last_step, load;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            cmp2_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            if (load) cmp2_q <= duty_i;
        end
    end

    // >= so a REPS/LEN shrunk mid-step ends the step instead of running the counter around
    always_comb begin
        step_end  = state_q == S_RUN && period_end_i &&
                    rep_q >= ((reps_i == 16'd0) ? 16'd0 : reps_i - 16'd1);
        last_step = idx_q >= len_i;
        state_d   = state_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        if (stop_i) state_d = S_IDLE;
        else if (start_i) begin
            state_d = S_RUN;
            idx_d   = '0;
            rep_d   = '0;
        end else if (state_q == S_RUN && period_end_i) begin
            rep_d = step_end ? 16'd0 : rep_q + 16'd1;
            if (step_end) begin
                if (!last_step) idx_d = idx_q + 1'b1;
                else if (loop_i) idx_d = '0;
                else state_d = S_DONE;
            end
        end
    end

    always_comb begin
        load       = !stop_i && (start_i || (step_end && (!last_step || loop_i)));
        done_set_o = !stop_i && !start_i && step_end && last_step && !loop_i;
        tmren_o    = state_q == S_RUN;
    end

    assign duty_idx_o = idx_d;
    assign state_o    = state_q;
    assign idx_o      = idx_q;
    assign tmrcmp2_o  = cmp2_q;
endmodule

// File: rtl/apb_pwm_seq.sv
// apb_pwm_seq: APB register file that sequences PWM32 duty compares through a table
module apb_pwm_seq
    import pwm_seq_pkg::*;
#(
    parameter int N_STEPS = 4
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [19:2] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        PERIOD_END,
    output logic [31:0] PRE,
    output logic [31:0] TMRCMP1,
    output logic [31:0] TMRCMP2,
    output logic        TMREN,
    output logic        IRQ
);
    localparam int IW = $clog2(N_STEPS);

    logic [5:0]    off;
    logic [2:0]    dsel;
    logic          wr, start, stop, duty_hit, loop_q, done_q, done_set, unused_ok;
    logic [31:0]   pre_q, cmp1_q, duty_rd;
    logic [15:0]   reps_q;
    logic [IW-1:0] len_q, duty_idx, idx;
    logic [31:0]   duty_q [N_STEPS];
    state_e        state;

    assign off       = {PADDR[5:2], 2'b00};
    assign dsel      = PADDR[4:2];
    assign wr        = PSEL && PWRITE && PENABLE;
    assign start     = wr && off == OFF_CTRL && PWDATA[0];
    assign stop      = wr && off == OFF_CTRL && PWDATA[1];
    assign duty_hit  = PADDR[5] && int'(dsel) < N_STEPS;
    assign duty_rd   = duty_q[duty_idx];
    assign unused_ok = &{1'b0, PADDR[19:6]};

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pre_q  <= '0;
            cmp1_q <= '0;
            reps_q <= '0;
            len_q  <= '0;
            loop_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < N_STEPS; i++) duty_q[i] <= '0;
        end else begin
            if (wr && off == OFF_CTRL)    loop_q <= PWDATA[2];
            if (wr && off == OFF_PRE)     pre_q  <= PWDATA;
            if (wr && off == OFF_TMRCMP1) cmp1_q <= PWDATA;
            if (wr && off == OFF_REPS)    reps_q <= PWDATA[15:0];
            if (wr && off == OFF_LEN)     len_q  <= PWDATA[IW-1:0];
            if (wr && duty_hit)           duty_q[dsel[IW-1:0]] <= PWDATA;
            done_q <= done_set || (done_q && !(wr && off == OFF_STATUS));
        end
    end

    always_comb begin
        case (off)
            OFF_CTRL:    PRDATA = {29'd0, loop_q, 2'b00};
            OFF_STATUS:  PRDATA = {26'd0, done_q, 3'(idx), state};
            OFF_PRE:     PRDATA = pre_q;
            OFF_TMRCMP1: PRDATA = cmp1_q;
            OFF_REPS:    PRDATA = {16'd0, reps_q};
            OFF_LEN:     PRDATA = 32'(len_q);
            default:     PRDATA = duty_hit ? duty_q[dsel[IW-1:0]] : RD_DEFAULT;
        endcase
    end

    pwm_seq_fsm #(.IW(IW)) u_fsm (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .start_i     (start),
        .stop_i      (stop),
        .loop_i      (loop_q),
        .period_end_i(PERIOD_END),
        .reps_i      (reps_q),
        .len_i       (len_q),
        .duty_i      (duty_rd),
        .duty_idx_o  (duty_idx),
        .state_o     (state),
        .idx_o       (idx),
        .tmrcmp2_o   (TMRCMP2),
        .tmren_o     (TMREN),
        .done_set_o  (done_set)
    );

    assign PREADY  = 1'b1;
    assign PRE     = pre_q;
    assign TMRCMP1 = cmp1_q;
    assign IRQ     = done_q;
endmodule
